// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, ROM address and 2-entry fetch buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [31:0] pc;
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        fault_pending;

  logic [31:0] ent_pc   [2];
  logic [31:0] ent_inst [2];
  logic        ent_fault[2];

  logic pop;
  logic push;

  // Head is only meaningful while valid; outputs read 0 when the buffer is empty.
  assign rom_addr  = pc;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = ((count != FULL) | pop) & ~redirect_valid;
  assign out_pc    = out_valid ? ent_pc[rd_ptr]    : 32'd0;
  assign out_inst  = out_valid ? ent_inst[rd_ptr]  : 32'd0;
  assign out_fault = out_valid ? ent_fault[rd_ptr] : 1'b0;

  // PC, pointers, occupancy; a redirect flushes the buffer and wins over any push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fault_pending <= 1'b0;
    end else if (redirect_valid) begin
      pc            <= {redirect_pc[31:2], 2'b00};
      fault_pending <= |redirect_pc[1:0];
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
    end else begin
      if (push) begin
        pc            <= pc + 32'd4;
        fault_pending <= 1'b0;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  // Entry storage: capture {pc, rom word, pending fault} at the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_pc[i]    <= 32'd0;
        ent_inst[i]  <= 32'd0;
        ent_fault[i] <= 1'b0;
      end
    end else if (push) begin
      ent_pc[wr_ptr]    <= pc;
      ent_inst[wr_ptr]  <= rom_data;
      ent_fault[wr_ptr] <= fault_pending;
    end
  end

endmodule
